note_search_stream: RTL and testbench

//  Streams a note table (note, 1/note pairs) against a latched fundamental and reports the entry

---
 rtl/note_search_stream.sv | 171 +++++++++++++++++
 tb/tb_note_search_stream.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/note_search_stream.sv
// Streams a note table against a latched fundamental and reports the nearest entry.
// Optional hysteresis toward the previous result: define NOTE_SEARCH_HYST_EN.
module note_search_stream #(
   parameter int unsigned FUNDAMENTAL_WIDTH = 38,
   parameter int unsigned INDEX_WIDTH       = 7,
   parameter int unsigned SUB_LATENCY       = 2,
   parameter logic [FUNDAMENTAL_WIDTH-1:0] HYST_MARGIN = FUNDAMENTAL_WIDTH'(1) << 19
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic [FUNDAMENTAL_WIDTH-1:0]     fundamental,
   input  logic                             fund_valid,
   input  logic [2*FUNDAMENTAL_WIDTH-1:0]   note_data,
   input  logic                             note_valid,
   input  logic                             note_last,
   output logic                             busy,
   output logic [FUNDAMENTAL_WIDTH-1:0]     inv_note,
   output logic [INDEX_WIDTH-1:0]           note_index,
   output logic [FUNDAMENTAL_WIDTH-1:0]     min_delta,
   output logic                             result_valid
);
   localparam int unsigned FW = FUNDAMENTAL_WIDTH;
   localparam int unsigned IW = INDEX_WIDTH;
   localparam int unsigned L  = SUB_LATENCY;

   typedef enum logic [1:0] {StIdle, StSweep, StFlush} state_e;

   state_e          state_q;
   logic [FW-1:0]   fund_q, run_min_q, run_inv_q;
   logic [IW-1:0]   run_idx_q, beat_idx_q;
   logic            done_q;

   logic            p_valid [L];
   logic            p_last  [L];
   logic [FW-1:0]   p_delta [L];
   logic [FW-1:0]   p_inv   [L];
   logic [IW-1:0]   p_idx   [L];

   logic            accept;
   logic [FW:0]     diff, diff_neg;
   logic [FW-1:0]   abs_in;

   always_comb begin
      accept   = (state_q == StSweep) && note_valid;
      diff     = {1'b0, note_data[2*FW-1:FW]} - {1'b0, fund_q};
      diff_neg = -diff;
      abs_in   = diff[FW] ? diff_neg[FW-1:0] : diff[FW-1:0];
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < L; i++) p_valid[i] <= 1'b0;
      end else begin
         p_valid[0] <= accept;
         for (int i = 1; i < L; i++) p_valid[i] <= p_valid[i-1];
      end
      p_last[0]  <= note_last;
      p_delta[0] <= abs_in;
      p_inv[0]   <= note_data[FW-1:0];
      p_idx[0]   <= beat_idx_q;
      for (int i = 1; i < L; i++) begin
         p_last[i]  <= p_last[i-1];
         p_delta[i] <= p_delta[i-1];
         p_inv[i]   <= p_inv[i-1];
         p_idx[i]   <= p_idx[i-1];
      end
   end

   logic [FW-1:0] sel_inv, sel_delta;
   logic [IW-1:0] sel_idx;

`ifdef NOTE_SEARCH_HYST_EN
   logic          has_result_q, prev_seen_q;
   logic [IW-1:0] prev_idx_q;
   logic [FW-1:0] prev_delta_q, prev_inv_q;
   logic [FW:0]   margin_sum;
   logic          keep_prev;

   always_comb begin
      margin_sum = {1'b0, run_min_q} + {1'b0, HYST_MARGIN};
      keep_prev  = has_result_q && prev_seen_q && (run_idx_q != prev_idx_q) &&
                   (margin_sum >= {1'b0, prev_delta_q});
      sel_inv    = keep_prev ? prev_inv_q   : run_inv_q;
      sel_idx    = keep_prev ? prev_idx_q   : run_idx_q;
      sel_delta  = keep_prev ? prev_delta_q : run_min_q;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         has_result_q <= 1'b0;
         prev_seen_q  <= 1'b0;
         prev_idx_q   <= '0;
         prev_delta_q <= '1;
         prev_inv_q   <= '0;
      end else if (state_q == StIdle && fund_valid && !result_valid) begin
         prev_seen_q <= 1'b0;
      end else if (p_valid[L-1] && has_result_q && p_idx[L-1] == prev_idx_q) begin
         prev_seen_q  <= 1'b1;
         prev_delta_q <= p_delta[L-1];
         prev_inv_q   <= p_inv[L-1];
      end else if (done_q) begin
         has_result_q <= 1'b1;
         prev_idx_q   <= sel_idx;
      end
   end
`else
   always_comb begin
      sel_inv   = run_inv_q;
      sel_idx   = run_idx_q;
      sel_delta = run_min_q;
   end
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         fund_q       <= '0;
         run_min_q    <= '1;
         run_inv_q    <= '0;
         run_idx_q    <= '0;
         beat_idx_q   <= '0;
         done_q       <= 1'b0;
         busy         <= 1'b0;
         inv_note     <= '0;
         note_index   <= '0;
         min_delta    <= '1;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // The cycle that carries result_valid never starts a new sweep.
               if (fund_valid && !result_valid) begin
                  state_q    <= StSweep;
                  fund_q     <= fundamental;
                  run_min_q  <= '1;
                  run_idx_q  <= '0;
                  beat_idx_q <= '0;
                  busy       <= 1'b1;
               end
            end
            StSweep: begin
               if (accept) begin
                  beat_idx_q <= beat_idx_q + 1'b1;
                  if (note_last) state_q <= StFlush;
               end
            end
            StFlush: begin
               if (done_q) begin
                  state_q      <= StIdle;
                  done_q       <= 1'b0;
                  busy         <= 1'b0;
                  result_valid <= 1'b1;
                  inv_note     <= sel_inv;
                  note_index   <= sel_idx;
                  min_delta    <= sel_delta;
               end
            end
            default: state_q <= StIdle;
         endcase
         if (p_valid[L-1]) begin
            if (p_delta[L-1] < run_min_q) begin
               run_min_q <= p_delta[L-1];
               run_inv_q <= p_inv[L-1];
               run_idx_q <= p_idx[L-1];
            end
            if (p_last[L-1]) done_q <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_note_search_stream.sv
// Directed bench for note_search_stream; expected results queued per sweep and checked on result_valid.
module tb_note_search_stream;
   localparam int FW = 38;
   localparam int IW = 7;
   localparam int L  = 2;
   localparam logic [FW-1:0] HM = 38'(4) << 21;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic [FW-1:0]   fundamental = '0;
   logic            fund_valid = 1'b0;
   logic [2*FW-1:0] note_data = '0;
   logic            note_valid = 1'b0;
   logic            note_last = 1'b0;
   logic            busy, result_valid;
   logic [FW-1:0]   inv_note, min_delta;
   logic [IW-1:0]   note_index;

   note_search_stream #(
      .FUNDAMENTAL_WIDTH(FW), .INDEX_WIDTH(IW), .SUB_LATENCY(L), .HYST_MARGIN(HM)
   ) dut (
      .clock(clock), .reset_n(reset_n), .fundamental(fundamental), .fund_valid(fund_valid),
      .note_data(note_data), .note_valid(note_valid), .note_last(note_last), .busy(busy),
      .inv_note(inv_note), .note_index(note_index), .min_delta(min_delta),
      .result_valid(result_valid)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [IW-1:0] idx;
      logic [FW-1:0] inv;
      logic [FW-1:0] delta;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   t4[$];
   int   t2[$];

   function automatic logic [FW-1:0] hz(input int h);
      logic [FW-1:0] v;
      v = 38'(h);
      return v << 21;
   endfunction

   function automatic logic [FW-1:0] inv_of(input int h);
      return 38'h10_0000_0000 + 38'(h);
   endfunction

   always @(negedge clock) begin
      if (reset_n && result_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", result_valid, 1'b0);
         end else begin
            mon_e = sb.pop_front();
            chk("note_index", note_index, mon_e.idx);
            chk("inv_note", inv_note, mon_e.inv);
            chk("min_delta", min_delta, mon_e.delta);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic sweep(input int fund_h, input int notes[$], input int ei, input int ed,
                        input bit gaps);
      exp_t e;
      int   k;
      // A beat offered while idle must not be taken.
      note_data  = {hz(fund_h), inv_of(fund_h)};
      note_valid = 1'b1;
      note_last  = 1'b1;
      step();
      note_valid = 1'b0;
      note_last  = 1'b0;
      chk("busy_idle", busy, 1'b0);
      e.idx   = IW'(ei);
      e.inv   = inv_of(notes[ei]);
      e.delta = hz(ed);
      sb.push_back(e);
      fundamental = hz(fund_h);
      fund_valid  = 1'b1;
      step();
      fund_valid = 1'b0;
      chk("busy_start", busy, 1'b1);
      for (int i = 0; i < notes.size(); i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               note_valid  = 1'b0;
               note_last   = 1'b1;
               fund_valid  = 1'b1;
               fundamental = hz(fund_h + 3);
               step();
            end
            fund_valid = 1'b0;
         end
         note_data  = {hz(notes[i]), inv_of(notes[i])};
         note_valid = 1'b1;
         note_last  = (i == notes.size() - 1);
         step();
      end
      note_valid = 1'b0;
      note_last  = 1'b0;
      k = 0;
      for (int c = 1; c <= 12; c++) begin
         if (gaps) begin
            // Beats after the last are ignored; this one would otherwise win with delta 0.
            note_data  = {hz(fund_h), inv_of(fund_h)};
            note_valid = 1'b1;
         end
         step();
         if (result_valid) begin
            k = c;
            break;
         end
      end
      note_valid = 1'b0;
      chk("result_latency", k, L + 1);
      chk("busy_at_result", busy, 1'b0);
      fundamental = hz(fund_h + 50);
      fund_valid  = 1'b1;
      step();
      fund_valid = 1'b0;
      chk("fund_valid_at_result_ignored", busy, 1'b0);
   endtask

   initial begin
      t4 = '{392, 415, 440, 466};
      t2 = '{420, 436};
      repeat (3) step();
      reset_n = 1'b1;
      step();
      chk("rst_inv_note", inv_note, '0);
      chk("rst_note_index", note_index, '0);
      chk("rst_min_delta", min_delta, {FW{1'b1}});
      chk("rst_result_valid", result_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);

      sweep(445, t4, 2, 5, 1'b0);
      sweep(428, t2, 0, 8, 1'b0);
      sweep(1000, t4, 3, 534, 1'b0);
      sweep(0, t4, 0, 392, 1'b0);

      sweep(445, t4, 2, 5, 1'b1);
      sweep(428, t2, 0, 8, 1'b1);
      sweep(1000, t4, 3, 534, 1'b1);
      sweep(0, t4, 0, 392, 1'b1);

      // Reset part-way through a sweep.
      fundamental = hz(445);
      fund_valid  = 1'b1;
      step();
      fund_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         note_data  = {hz(t4[i]), inv_of(t4[i])};
         note_valid = 1'b1;
         step();
      end
      note_valid = 1'b0;
      reset_n    = 1'b0;
      step();
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         chk("abort_no_result", result_valid, 1'b0);
      end
      chk("abort_inv_note", inv_note, '0);
      chk("abort_note_index", note_index, '0);
      chk("abort_min_delta", min_delta, {FW{1'b1}});
      chk("abort_busy", busy, 1'b0);

      sweep(445, t4, 2, 5, 1'b0);
`ifdef NOTE_SEARCH_HYST_EN
      sweep(454, t4, 2, 14, 1'b0);
`else
      sweep(454, t4, 3, 12, 1'b0);
`endif
      repeat (3) step();
      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
